// File: rtl/phase_sequencer.sv
// phase_sequencer
//    Sequencing controller for the five-phase instruction cycle
//    (P1 fetch .. P5 writeback). It holds the register-file clear after
//    reset. It then steps the datapath through one-hot phase strobes
//    under run/stop/single-step control from the exec/step buttons. It
//    also honours datapath halt and stall requests.
//
// Ports
//    clock          in   system clock, rising edge
//    reset          in   synchronous, active-high
//    exec           in   run/stop button (level, rising edge acts)
//    step           in   single-instruction button (level, rising edge acts)
//    halt           in   datapath halt request (level)
//    stall          in   datapath wait, freezes the phase while high
//    register_reset out  register-file clear, high during INIT
//    phase          out  current phase index 0..4, 0 when inactive
//    p1..p5         out  one-hot phase strobes, all 0 when inactive
//    running        out  high while stepping through phases (RUN or STEP)
//    halted         out  high in HALTED
//    instr_count    out  instructions retired since reset, wraps
module phase_sequencer #(
   parameter int unsigned INIT_CYCLES = 4,
   parameter int unsigned COUNT_W     = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               exec,
   input  logic               step,
   input  logic               halt,
   input  logic               stall,
   output logic               register_reset,
   output logic [2:0]         phase,
   output logic               p1,
   output logic               p2,
   output logic               p3,
   output logic               p4,
   output logic               p5,
   output logic               running,
   output logic               halted,
   output logic [COUNT_W-1:0] instr_count
);

   typedef enum logic [2:0] {
      S_INIT,
      S_IDLE,
      S_RUN,
      S_STEP,
      S_HALTED
   } state_t;

   localparam logic [3:0] INIT_LAST  = 4'(INIT_CYCLES - 1);
   localparam logic [2:0] LAST_PHASE = 3'd4;

   state_t               state_q,     state_d;
   logic [3:0]           init_cnt_q,  init_cnt_d;
   logic                 reg_reset_q, reg_reset_d;
   logic [2:0]           phase_q,     phase_d;
   logic [4:0]           strobe_q,    strobe_d;   // {p5,p4,p3,p2,p1}
   logic                 running_q,   running_d;
   logic                 halted_q,    halted_d;
   logic [COUNT_W-1:0]   count_q,     count_d;
   logic                 stop_req_q,  stop_req_d;
   logic                 halt_req_q,  halt_req_d;
   logic                 exec_q;
   logic                 step_q;

   logic                 exec_rise;
   logic                 step_rise;

   // Button history resets to 1 so a button held through reset is not
   // mistaken for a fresh press.
   assign exec_rise = exec & ~exec_q;
   assign step_rise = step & ~step_q;

   always_comb begin
      state_d     = state_q;
      init_cnt_d  = init_cnt_q;
      reg_reset_d = reg_reset_q;
      phase_d     = phase_q;
      strobe_d    = strobe_q;
      running_d   = running_q;
      halted_d    = halted_q;
      count_d     = count_q;
      stop_req_d  = stop_req_q;
      halt_req_d  = halt_req_q;

      unique case (state_q)
         S_INIT: begin
            // Count from 0 after reset; register_reset drops on the
            // INIT_CYCLES-th edge after reset release.
            if (init_cnt_q == INIT_LAST) begin
               state_d     = S_IDLE;
               reg_reset_d = 1'b0;
            end else begin
               init_cnt_d = init_cnt_q + 4'd1;
            end
         end

         S_IDLE: begin
            if (exec_rise || step_rise) begin
               state_d    = exec_rise ? S_RUN : S_STEP;
               phase_d    = '0;
               strobe_d   = 5'b00001;
               running_d  = 1'b1;
               stop_req_d = 1'b0;
               halt_req_d = 1'b0;
            end
         end

         S_RUN, S_STEP: begin
            // Requests are captured on any cycle, stalled or not, and
            // only act at the end of the current instruction.
            if (state_q == S_RUN && exec_rise) begin
               stop_req_d = 1'b1;
            end
            if (halt) begin
               halt_req_d = 1'b1;
            end

            if (!stall) begin
               if (phase_q == LAST_PHASE) begin
                  count_d = count_q + 1'b1;
                  if (halt_req_q || halt) begin
                     state_d    = S_HALTED;
                     halted_d   = 1'b1;
                     phase_d    = '0;
                     strobe_d   = '0;
                     running_d  = 1'b0;
                     stop_req_d = 1'b0;
                     halt_req_d = 1'b0;
                  end else if (state_q == S_STEP || stop_req_q) begin
                     state_d    = S_IDLE;
                     phase_d    = '0;
                     strobe_d   = '0;
                     running_d  = 1'b0;
                     stop_req_d = 1'b0;
                  end else begin
                     phase_d  = '0;
                     strobe_d = 5'b00001;
                  end
               end else begin
                  phase_d  = phase_q + 3'd1;
                  strobe_d = strobe_q << 1;
               end
            end
         end

         S_HALTED: begin
            if (exec_rise) begin
               state_d  = S_IDLE;
               halted_d = 1'b0;
            end
         end

         default: begin
            state_d     = S_INIT;
            init_cnt_d  = '0;
            reg_reset_d = 1'b1;
            phase_d     = '0;
            strobe_d    = '0;
            running_d   = 1'b0;
            halted_d    = 1'b0;
            stop_req_d  = 1'b0;
            halt_req_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_INIT;
         init_cnt_q  <= '0;
         reg_reset_q <= 1'b1;
         phase_q     <= '0;
         strobe_q    <= '0;
         running_q   <= 1'b0;
         halted_q    <= 1'b0;
         count_q     <= '0;
         stop_req_q  <= 1'b0;
         halt_req_q  <= 1'b0;
         exec_q      <= 1'b1;
         step_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         init_cnt_q  <= init_cnt_d;
         reg_reset_q <= reg_reset_d;
         phase_q     <= phase_d;
         strobe_q    <= strobe_d;
         running_q   <= running_d;
         halted_q    <= halted_d;
         count_q     <= count_d;
         stop_req_q  <= stop_req_d;
         halt_req_q  <= halt_req_d;
         exec_q      <= exec;
         step_q      <= step;
      end
   end

   assign register_reset = reg_reset_q;
   assign phase          = phase_q;
   assign p1             = strobe_q[0];
   assign p2             = strobe_q[1];
   assign p3             = strobe_q[2];
   assign p4             = strobe_q[3];
   assign p5             = strobe_q[4];
   assign running        = running_q;
   assign halted         = halted_q;
   assign instr_count    = count_q;

   // At most one strobe, and running exactly when a strobe is live.
   a_strobe_onehot0 : assert property (@(posedge clock) $onehot0(strobe_q));
   a_running_strobe : assert property (@(posedge clock) running_q == $onehot(strobe_q));

endmodule

// File: tb/tb_phase_sequencer.sv
module tb_phase_sequencer;

   logic clock = 1'b0;
   logic reset, exec, step, halt, stall;

   // main instance: INIT_CYCLES=4, COUNT_W=16
   logic        m_rr, m_p1, m_p2, m_p3, m_p4, m_p5, m_run, m_hlt;
   logic [2:0]  m_ph;
   logic [15:0] m_cnt;
   // narrow counter instance: INIT_CYCLES=4, COUNT_W=3 (exercises wrap)
   logic        w_rr, w_p1, w_p2, w_p3, w_p4, w_p5, w_run, w_hlt;
   logic [2:0]  w_ph;
   logic [2:0]  w_cnt;
   // minimum init instance: INIT_CYCLES=1, COUNT_W=16
   logic        i_rr, i_p1, i_p2, i_p3, i_p4, i_p5, i_run, i_hlt;
   logic [2:0]  i_ph;
   logic [15:0] i_cnt;

   phase_sequencer #(.INIT_CYCLES(4), .COUNT_W(16)) dut (
      .clock(clock), .reset(reset), .exec(exec), .step(step), .halt(halt), .stall(stall),
      .register_reset(m_rr), .phase(m_ph), .p1(m_p1), .p2(m_p2), .p3(m_p3), .p4(m_p4),
      .p5(m_p5), .running(m_run), .halted(m_hlt), .instr_count(m_cnt));

   phase_sequencer #(.INIT_CYCLES(4), .COUNT_W(3)) dut_w3 (
      .clock(clock), .reset(reset), .exec(exec), .step(step), .halt(halt), .stall(stall),
      .register_reset(w_rr), .phase(w_ph), .p1(w_p1), .p2(w_p2), .p3(w_p3), .p4(w_p4),
      .p5(w_p5), .running(w_run), .halted(w_hlt), .instr_count(w_cnt));

   phase_sequencer #(.INIT_CYCLES(1), .COUNT_W(16)) dut_i1 (
      .clock(clock), .reset(reset), .exec(exec), .step(step), .halt(halt), .stall(stall),
      .register_reset(i_rr), .phase(i_ph), .p1(i_p1), .p2(i_p2), .p3(i_p3), .p4(i_p4),
      .p5(i_p5), .running(i_run), .halted(i_hlt), .instr_count(i_cnt));

   always #5 clock = ~clock;

   int unsigned cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      int unsigned due;
      string       name;
      logic        rr;
      logic        rr1;
      logic [2:0]  ph;
      logic [4:0]  pb;
      logic        run;
      logic        hlt;
      logic [15:0] cnt;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;

   // Expected outputs after the next rising edge.
   task automatic push(input string nm, input logic rr, input logic rr1, input logic [2:0] ph,
                       input logic [4:0] pb, input logic run, input logic hlt, input logic [15:0] cnt);
      exp_t e;
      e.due = cyc + 1;
      e.name = nm;
      e.rr = rr;
      e.rr1 = rr1;
      e.ph = ph;
      e.pb = pb;
      e.run = run;
      e.hlt = hlt;
      e.cnt = cnt;
      sbq.push_back(e);
   endtask

   task automatic exp_ph(input string nm, input int p, input logic [15:0] cnt);
      push(nm, 1'b0, 1'b0, 3'(p), 5'(1 << p), 1'b1, 1'b0, cnt);
   endtask

   task automatic exp_q(input string nm, input logic rr, input logic rr1, input logic hlt,
                        input logic [15:0] cnt);
      push(nm, rr, rr1, 3'd0, 5'd0, 1'b0, hlt, cnt);
   endtask

   // Apply inputs for one rising edge (called at a falling edge).
   task automatic drive(input logic r, input logic e, input logic s, input logic h, input logic st);
      reset = r;
      exec  = e;
      step  = s;
      halt  = h;
      stall = st;
      @(negedge clock);
   endtask

   // Monitor: pops and compares every expectation due at this cycle.
   initial begin
      exp_t e;
      logic [26:0] got_m, exp_m, got_i, exp_i;
      logic [13:0] got_w, exp_w;
      forever begin
         @(negedge clock);
         while (sbq.size() != 0 && sbq[0].due <= cyc) begin
            e = sbq.pop_front();
            if (e.due != cyc) begin
               checks++;
               errors++;
               $display("FAIL %s: expectation for cycle %0d missed (now %0d)", e.name, e.due, cyc);
            end else begin
               got_m = {m_rr, m_ph, m_p5, m_p4, m_p3, m_p2, m_p1, m_run, m_hlt, m_cnt};
               exp_m = {e.rr, e.ph, e.pb, e.run, e.hlt, e.cnt};
               got_w = {w_rr, w_ph, w_p5, w_p4, w_p3, w_p2, w_p1, w_run, w_hlt, w_cnt};
               exp_w = {e.rr, e.ph, e.pb, e.run, e.hlt, e.cnt[2:0]};
               got_i = {i_rr, i_ph, i_p5, i_p4, i_p3, i_p2, i_p1, i_run, i_hlt, i_cnt};
               exp_i = {e.rr1, e.ph, e.pb, e.run, e.hlt, e.cnt};
               checks += 3;
               if (got_m !== exp_m) begin
                  errors++;
                  $display("FAIL %s main @%0d: got rr=%b ph=%0d pb=%b run=%b hlt=%b cnt=%h, expected rr=%b ph=%0d pb=%b run=%b hlt=%b cnt=%h",
                           e.name, cyc, m_rr, m_ph, {m_p5, m_p4, m_p3, m_p2, m_p1}, m_run, m_hlt, m_cnt,
                           e.rr, e.ph, e.pb, e.run, e.hlt, e.cnt);
               end
               if (got_w !== exp_w) begin
                  errors++;
                  $display("FAIL %s w3 @%0d: got %h, expected %h", e.name, cyc, got_w, exp_w);
               end
               if (got_i !== exp_i) begin
                  errors++;
                  $display("FAIL %s i1 @%0d: got %h, expected %h", e.name, cyc, got_i, exp_i);
               end
            end
         end
      end
   end

   initial begin
      reset = 1'b1; exec = 1'b1; step = 1'b0; halt = 1'b0; stall = 1'b0;
      @(negedge clock);

      // Reset with exec held high
      drive(1, 1, 0, 0, 0);
      exp_q("reset", 1, 1, 0, 0);                  drive(1, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         exp_q("init_hold", 1, 0, 0, 0);            drive(0, 1, 0, 0, 0);
      end
      exp_q("init_done", 0, 0, 0, 0);              drive(0, 1, 0, 0, 0);
      for (int i = 0; i < 2; i++) begin
         exp_q("held_exec_no_run", 0, 0, 0, 0);     drive(0, 1, 0, 0, 0);
      end
      exp_q("exec_low_idle", 0, 0, 0, 0);          drive(0, 0, 0, 0, 0);

      // Run: three instructions
      exp_ph("run_start", 0, 0);                   drive(0, 1, 0, 0, 0);
      for (int n = 0; n < 3; n++) begin
         for (int p = 1; p < 5; p++) begin
            exp_ph("run_phase", p, 16'(n));         drive(0, 0, 0, 0, 0);
         end
         exp_ph("run_retire", 0, 16'(n + 1));       drive(0, 0, 0, 0, 0);
      end

      // Stop request in P2 completes the instruction
      exp_ph("stop_p2", 1, 3);                     drive(0, 0, 0, 0, 0);
      exp_ph("stop_p3", 2, 3);                     drive(0, 1, 0, 0, 0);
      exp_ph("stop_p4", 3, 3);                     drive(0, 0, 0, 0, 0);
      exp_ph("stop_p5", 4, 3);                     drive(0, 0, 0, 0, 0);
      exp_q("stop_idle", 0, 0, 0, 4);              drive(0, 0, 0, 0, 0);

      // Single step
      exp_ph("step_p1", 0, 4);                     drive(0, 0, 1, 0, 0);
      for (int p = 1; p < 5; p++) begin
         exp_ph("step_phase", p, 4);                drive(0, 0, 0, 0, 0);
      end
      exp_q("step_idle", 0, 0, 0, 5);              drive(0, 0, 0, 0, 0);
      exp_q("step_idle_stay", 0, 0, 0, 5);         drive(0, 0, 0, 0, 0);

      // exec and step together: RUN wins, keeps going after P5
      exp_ph("both_run", 0, 5);                    drive(0, 1, 1, 0, 0);
      for (int p = 1; p < 5; p++) begin
         exp_ph("both_phase", p, 5);                drive(0, 0, 0, 0, 0);
      end
      exp_ph("both_continues", 0, 6);              drive(0, 0, 0, 0, 0);

      // Stall for 3 cycles in P3
      exp_ph("pre_stall_p2", 1, 6);                drive(0, 0, 0, 0, 0);
      exp_ph("pre_stall_p3", 2, 6);                drive(0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         exp_ph("stall_hold_p3", 2, 6);             drive(0, 0, 0, 0, 1);
      end
      exp_ph("stall_release_p4", 3, 6);            drive(0, 0, 0, 0, 0);
      exp_ph("stall_p5", 4, 6);                    drive(0, 0, 0, 0, 0);

      // Halt pulse in P1: instruction completes, then HALTED
      exp_ph("halt_p1", 0, 7);                     drive(0, 0, 0, 0, 0);
      exp_ph("halt_p2", 1, 7);                     drive(0, 0, 0, 1, 0);
      for (int p = 2; p < 5; p++) begin
         exp_ph("halt_finish", p, 7);               drive(0, 0, 0, 0, 0);
      end
      exp_q("halted", 0, 0, 1, 8);                 drive(0, 0, 0, 0, 0);
      exp_q("halted_hold", 0, 0, 1, 8);            drive(0, 0, 0, 0, 0);
      exp_q("halted_step_ignored", 0, 0, 1, 8);    drive(0, 0, 1, 0, 0);
      exp_q("halted_hold2", 0, 0, 1, 8);           drive(0, 0, 0, 0, 0);
      exp_q("halt_exit", 0, 0, 0, 8);              drive(0, 1, 0, 0, 0);
      exp_q("idle_after_halt", 0, 0, 0, 8);        drive(0, 0, 0, 0, 0);

      // Stall in P5 blocks retirement; then reset in P4
      exp_ph("rst_run_p1", 0, 8);                  drive(0, 1, 0, 0, 0);
      for (int p = 1; p < 5; p++) begin
         exp_ph("rst_run", p, 8);                   drive(0, 0, 0, 0, 0);
      end
      exp_ph("p5_stall_no_retire", 4, 8);          drive(0, 0, 0, 0, 1);
      exp_ph("p5_retire", 0, 9);                   drive(0, 0, 0, 0, 0);
      for (int p = 1; p < 4; p++) begin
         exp_ph("to_p4", p, 9);                     drive(0, 0, 0, 0, 0);
      end
      exp_q("mid_reset", 1, 1, 0, 0);              drive(1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         exp_q("reinit_hold", 1, 0, 0, 0);          drive(0, 0, 0, 0, 0);
      end
      exp_q("reinit_done", 0, 0, 0, 0);            drive(0, 0, 0, 0, 0);
      exp_q("reinit_idle", 0, 0, 0, 0);            drive(0, 0, 0, 0, 0);

      // Drain the scoreboard with a bound
      repeat (2) @(negedge clock);
      for (int i = 0; i < 10 && sbq.size() != 0; i++) @(negedge clock);
      if (sbq.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations left unchecked, expected 0", sbq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
